// File: rtl/jpeg_sram_pkg.sv
// Shared types for the JPEG strip buffer: FSM states, SRAM command encodings and address split.
package jpeg_sram_pkg;

   typedef enum logic [1:0] {ST_WRITE, ST_READ, ST_FLUSH} state_t;

   // Command encodings are {NCE, NWRT}
   localparam logic [1:0] CMD_IDLE  = 2'b11;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b00;

   localparam int RA_W = 11;
   localparam int CA_W = 4;
   localparam int SA_W = RA_W + CA_W;

   typedef struct packed {
      logic [RA_W-1:0] ra;
      logic [CA_W-1:0] ca;
   } sram_addr_t;

   function automatic sram_addr_t split_addr(input logic [SA_W-1:0] addr);
      sram_addr_t a;
      a.ra = addr[SA_W-1:CA_W];
      a.ca = addr[CA_W-1:0];
      return a;
   endfunction

endpackage

// File: rtl/sync_fifo_tagged.sv
// Show-ahead synchronous FIFO holding a sample plus its tag bits; head is visible while count is nonzero.
module sync_fifo_tagged #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 18,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only observed once counted.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/sram_strip_blocker.sv
// Strip buffer controller: writes an 8-row raster strip into SRAM, then reads it back in 8x8 block order.
module sram_strip_blocker
   import jpeg_sram_pkg::*;
#(
   parameter int IMG_WIDTH   = 64,
   parameter int WORDSIZE    = 16,
   parameter int ADDRESSSIZE = 15,
   parameter int OFIFO_DEPTH = 4
) (
   input  logic                iClk,
   input  logic                iReset,
   input  logic                iValid,
   input  logic [WORDSIZE-1:0] iData,
   output logic                oReady,
   output logic                oValid,
   output logic [WORDSIZE-1:0] oData,
   output logic                oBlockLast,
   output logic                oStripLast,
   input  logic                iReady,
   output logic                oNCE,
   output logic                oNWRT,
   output logic [10:0]         oRA,
   output logic [3:0]          oCA,
   output logic [WORDSIZE-1:0] oDIN,
   input  logic [WORDSIZE-1:0] iDO
);
   localparam int NUM_BLOCKS = IMG_WIDTH / 8;
   localparam int CW  = $clog2(OFIFO_DEPTH + 1);
   localparam int CRW = CW + 1;
   localparam int FW  = WORDSIZE + 2;
   localparam logic [ADDRESSSIZE-1:0] WR_LAST = ADDRESSSIZE'(8 * IMG_WIDTH - 1);
   localparam logic [8:0]             B_LAST  = 9'(NUM_BLOCKS - 1);

   state_t                state_q, state_d;
   logic [ADDRESSSIZE-1:0] wr_cnt_q, wr_cnt_d;
   logic [2:0]            c_q, c_d, r_q, r_d;
   logic [8:0]            b_q, b_d;
   logic [1:0]            cmd_q, cmd_d;
   logic [ADDRESSSIZE-1:0] addr_q, addr_d;
   logic [WORDSIZE-1:0]   din_q, din_d;
   logic                  v1_q, v1_d, v2_q, v2_d;
   logic [1:0]            tag1_q, tag1_d, tag2_q, tag2_d;

   logic [ADDRESSSIZE-1:0] rd_addr;
   logic                  block_last, strip_last, credit_ok, pop;
   logic [CW-1:0]         fifo_count;
   logic [CRW-1:0]        credit_used;
   logic [FW-1:0]         head;
   sram_addr_t            sa;

   assign rd_addr    = ADDRESSSIZE'(int'(r_q) * IMG_WIDTH + int'(b_q) * 8 + int'(c_q));
   assign block_last = (r_q == 3'd7) && (c_q == 3'd7);
   assign strip_last = block_last && (b_q == B_LAST);

   // Reads already issued but not yet in the FIFO still hold a slot, so overflow cannot happen.
   assign credit_used = CRW'(fifo_count) + CRW'(v1_q) + CRW'(v2_q);
   assign credit_ok   = int'(credit_used) < OFIFO_DEPTH;

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      c_d      = c_q;
      r_d      = r_q;
      b_d      = b_q;
      cmd_d    = CMD_IDLE;
      addr_d   = addr_q;
      din_d    = din_q;
      v1_d     = 1'b0;
      tag1_d   = tag1_q;
      v2_d     = v1_q;
      tag2_d   = tag1_q;
      unique case (state_q)
         ST_WRITE: begin
            if (iValid && oReady) begin
               cmd_d  = CMD_WRITE;
               addr_d = wr_cnt_q;
               din_d  = iData;
               if (wr_cnt_q == WR_LAST) begin
                  wr_cnt_d = '0;
                  state_d  = ST_READ;
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         ST_READ: begin
            if (credit_ok) begin
               cmd_d  = CMD_READ;
               addr_d = rd_addr;
               v1_d   = 1'b1;
               tag1_d = {strip_last, block_last};
               c_d    = c_q + 3'd1;
               if (c_q == 3'd7) begin
                  r_d = r_q + 3'd1;
                  if (r_q == 3'd7) b_d = (b_q == B_LAST) ? '0 : b_q + 9'd1;
               end
               if (strip_last) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (pop && oStripLast) state_d = ST_WRITE;
         end
         default: state_d = ST_WRITE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q  <= ST_WRITE;
         wr_cnt_q <= '0;
         c_q      <= '0;
         r_q      <= '0;
         b_q      <= '0;
         cmd_q    <= CMD_IDLE;
         addr_q   <= '0;
         din_q    <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         tag1_q   <= '0;
         tag2_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         c_q      <= c_d;
         r_q      <= r_d;
         b_q      <= b_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         tag1_q   <= tag1_d;
         tag2_q   <= tag2_d;
      end
   end

   sync_fifo_tagged #(
      .DEPTH (OFIFO_DEPTH),
      .WIDTH (FW)
   ) u_ofifo (
      .clk       (iClk),
      .reset     (iReset),
      .push      (v2_q),
      .push_data ({tag2_q, iDO}),
      .pop       (pop),
      .head_data (head),
      .count     (fifo_count)
   );

   assign oValid     = (fifo_count != '0);
   assign pop        = oValid && iReady;
   assign oData      = oValid ? head[WORDSIZE-1:0] : '0;
   assign oBlockLast = oValid && head[WORDSIZE];
   assign oStripLast = oValid && head[WORDSIZE+1];
   assign oReady     = (state_q == ST_WRITE) && !iReset;

   assign sa    = split_addr(SA_W'(addr_q));
   assign oRA   = sa.ra;
   assign oCA   = sa.ca;
   assign oNCE  = cmd_q[1];
   assign oNWRT = cmd_q[0];
   assign oDIN  = din_q;

endmodule

// File: tb/tb_sram_strip_blocker.sv
// Directed bench for sram_strip_blocker with a behavioural SRAM and protocol monitor.
module tb_sram_strip_blocker;

   localparam int W = 16;

   logic        iClk = 1'b0;
   logic        iReset, iValid, iReady;
   logic [15:0] iData, oData, oDIN;
   logic [15:0] iDO = '0;
   logic        oReady, oValid, oBlockLast, oStripLast, oNCE, oNWRT;
   logic [10:0] oRA;
   logic [3:0]  oCA;

   logic [15:0] sram [32768];
   logic [17:0] outQ [$];

   int checks = 0, failures = 0;
   int protoErr = 0, stabErr = 0;
   int writeCnt = 0, readCnt = 0;
   int readyMode = 0, stallLeft = 0;
   bit stallDone = 0, monEn = 0, prevFire = 0, holdValid = 0, stripSeen = 0;
   logic [17:0] held;

   sram_strip_blocker #(.IMG_WIDTH(W)) dut (
      .iClk(iClk), .iReset(iReset), .iValid(iValid), .iData(iData), .oReady(oReady),
      .oValid(oValid), .oData(oData), .oBlockLast(oBlockLast), .oStripLast(oStripLast),
      .iReady(iReady), .oNCE(oNCE), .oNWRT(oNWRT), .oRA(oRA), .oCA(oCA),
      .oDIN(oDIN), .iDO(iDO)
   );

   always #5 iClk = ~iClk;

   // Behavioural SRAM: Q updates the cycle after a read command and holds otherwise
   always @(posedge iClk) begin
      if (!oNCE) begin
         if (!oNWRT) sram[{oRA, oCA}] <= oDIN;
         else        iDO <= sram[{oRA, oCA}];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] expSample(input int base, input int n);
      int b, r, c, v;
      logic bl, sl;
      b  = n / 64;
      r  = (n / 8) % 8;
      c  = n % 8;
      v  = base + r * W + b * 8 + c;
      bl = (r == 7) && (c == 7);
      sl = bl && (b == W / 8 - 1);
      return {14'd0, sl, bl, v[15:0]};
   endfunction

   // Output collector, stall-stability and SRAM protocol monitor, all sampled mid-cycle
   initial begin
      forever begin
         @(negedge iClk);
         if (monEn && !iReset) begin
            if (!oNWRT && oNCE) protoErr++;
            if ((!oNCE && !oNWRT) != prevFire) protoErr++;
            if (!oNCE && !oNWRT) writeCnt++;
            if (!oNCE && oNWRT) readCnt++;
            if (int'(dut.credit_used) > 4) protoErr++;
            prevFire = iValid && oReady;
            if (stripSeen) begin
               checkOutput("ready_after_striplast", 32'(oReady), 32'd1);
               stripSeen = 0;
            end
            if (oValid && !iReady) begin
               if (holdValid && ({oStripLast, oBlockLast, oData} !== held)) stabErr++;
               held = {oStripLast, oBlockLast, oData};
               holdValid = 1;
            end else begin
               holdValid = 0;
            end
            if (oValid && iReady) begin
               outQ.push_back({oStripLast, oBlockLast, oData});
               if (oStripLast) begin
                  checkOutput("ready_low_in_flush", 32'(oReady), 32'd0);
                  stripSeen = 1;
               end
            end
         end else begin
            prevFire = 0;
            holdValid = 0;
         end
      end
   end

   // Consumer ready pattern: always ready, or toggling with one long stall
   initial begin
      iReady = 1'b0;
      forever begin
         @(posedge iClk); #1;
         if (readyMode == 0) iReady = 1'b1;
         else if (stallLeft > 0) begin iReady = 1'b0; stallLeft--; end
         else if (!stallDone && outQ.size() >= 30) begin stallDone = 1; stallLeft = 19; iReady = 1'b0; end
         else iReady = ~iReady;
      end
   end

   task automatic applyStimulus(input int base, input bit gapped);
      int k = 0;
      int guard = 0;
      while (k < 128 && guard < 4000) begin
         guard++;
         if (gapped && $urandom_range(0, 1) == 0) iValid = 1'b0;
         else begin iValid = 1'b1; iData = 16'(base + k); end
         @(negedge iClk);
         if (iValid && oReady) k++;
         @(posedge iClk); #1;
      end
      iValid = 1'b0;
      checkOutput($sformatf("feed_%0d_done", base), 32'(k), 32'd128);
   endtask

   task automatic startTest();
      outQ.delete();
      writeCnt = 0;
      readCnt = 0;
      stallDone = 0;
      stallLeft = 0;
   endtask

   task automatic waitOutputs(input string name, input int n);
      int guard = 0;
      while (outQ.size() < n && guard < 8000) begin @(negedge iClk); guard++; end
      repeat (10) @(negedge iClk);
      checkOutput($sformatf("%s_out_count", name), 32'(outQ.size()), 32'(n));
      @(posedge iClk); #1;
   endtask

   task automatic checkStrip(input string name, input int base, input int idx0);
      for (int n = 0; n < 128; n++)
         if (idx0 + n < outQ.size())
            checkOutput($sformatf("%s_out%0d", name, n), 32'(outQ[idx0 + n]), expSample(base, n));
   endtask

   task automatic checkCounts(input string name, input int strips);
      checkOutput($sformatf("%s_writes", name), 32'(writeCnt), 32'(128 * strips));
      checkOutput($sformatf("%s_reads", name), 32'(readCnt), 32'(128 * strips));
   endtask

   initial begin
      int guard;
      iReset = 1'b1; iValid = 1'b0; iData = '0;
      @(posedge iClk); @(posedge iClk); @(negedge iClk);
      checkOutput("reset_ready", 32'(oReady), 32'd0);
      checkOutput("reset_valid", 32'(oValid), 32'd0);
      checkOutput("reset_tags", 32'({oBlockLast, oStripLast}), 32'd0);
      checkOutput("reset_cmd", 32'({oNCE, oNWRT}), 32'd3);
      checkOutput("reset_addr", 32'({oRA, oCA}), 32'd0);
      checkOutput("reset_din", 32'(oDIN), 32'd0);
      @(posedge iClk); #1;
      iReset = 1'b0;
      monEn = 1;
      @(negedge iClk);
      checkOutput("ready_after_reset", 32'(oReady), 32'd1);
      @(posedge iClk); #1;

      $display("[TB] test 1: contiguous strip, consumer always ready");
      startTest(); readyMode = 0;
      applyStimulus(0, 0);
      waitOutputs("t1", 128);
      checkStrip("t1", 0, 0);
      if (outQ.size() >= 128) begin
         checkOutput("t1_first", 32'(outQ[0]), 32'd0);
         checkOutput("t1_row1", 32'(outQ[8]), 32'd16);
         checkOutput("t1_sample64", 32'(outQ[64]), 32'd8);
         checkOutput("t1_blocklast63", 32'(outQ[63]), 32'h10000 | 32'd119);
         checkOutput("t1_striplast127", 32'(outQ[127]), 32'h30000 | 32'd127);
      end
      checkCounts("t1", 1);

      $display("[TB] test 2: gapped input");
      startTest();
      applyStimulus(0, 1);
      waitOutputs("t2", 128);
      checkStrip("t2", 0, 0);
      checkCounts("t2", 1);

      $display("[TB] test 3: toggling consumer with long stall");
      startTest(); readyMode = 1;
      applyStimulus(0, 0);
      waitOutputs("t3", 128);
      checkStrip("t3", 0, 0);
      checkCounts("t3", 1);
      readyMode = 0;

      $display("[TB] test 4: back-to-back strips");
      startTest();
      applyStimulus(0, 0);
      applyStimulus(1000, 0);
      waitOutputs("t4", 256);
      checkStrip("t4a", 0, 0);
      checkStrip("t4b", 1000, 128);
      if (outQ.size() > 128) checkOutput("t4_second_first", 32'(outQ[128]), 32'd1000);
      checkCounts("t4", 2);

      $display("[TB] test 5: reset mid-readout");
      startTest();
      applyStimulus(0, 0);
      guard = 0;
      while (outQ.size() < 40 && guard < 4000) begin @(negedge iClk); guard++; end
      checkOutput("t5_reached_40", 32'(outQ.size() >= 40), 32'd1);
      @(posedge iClk); #1;
      iReset = 1'b1;
      @(negedge iClk);
      checkOutput("t5_ready_in_reset", 32'(oReady), 32'd0);
      @(posedge iClk); #1;
      iReset = 1'b0;
      @(negedge iClk);
      checkOutput("t5_valid_after_reset", 32'(oValid), 32'd0);
      checkOutput("t5_nce_after_reset", 32'(oNCE), 32'd1);
      checkOutput("t5_ready_after_reset", 32'(oReady), 32'd1);
      @(posedge iClk); #1;
      startTest();
      applyStimulus(500, 0);
      waitOutputs("t5", 128);
      checkStrip("t5", 500, 0);
      if (outQ.size() > 0) checkOutput("t5_first", 32'(outQ[0]), 32'd500);
      checkCounts("t5", 1);

      checkOutput("sram_protocol", 32'(protoErr), 32'd0);
      checkOutput("stall_stable", 32'(stabErr), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
